// File: rtl/btn_pulse_conditioner.sv
// Pushbutton conditioner: 2-FF synchroniser, stable-count debounce and a
// press/auto-repeat strobe generator feeding the combo-lock datapath.
module btn_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic pulse,
    output logic held
);

    localparam int DebW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RepW   = $clog2(RepMax + 1);

    localparam logic [DebW-1:0] DebLast      = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] RepDelayLoad = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RepRateLoad  = RepW'(REPEAT_RATE - 1);

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_DELAY  = 2'd1;
    localparam logic [1:0] STATE_REPEAT = 2'd2;
    localparam logic [1:0] STATE_HOLD   = 2'd3;

    logic            syncMeta;
    logic            syncOut;
    logic [DebW-1:0] debCnt;
    logic            levelChange;
    logic            levelRise;
    logic            levelFall;

    logic [1:0]      state;
    logic [1:0]      stateNext;
    logic [RepW-1:0] repCnt;
    logic [RepW-1:0] repCntNext;
    logic            pulseNext;
    logic            heldNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncMeta <= 1'b0;
            syncOut  <= 1'b0;
        end else begin
            syncMeta <= btn_in;
            syncOut  <= syncMeta;
        end
    end

    // The FSM reacts to the level edge in the same cycle it is accepted, so
    // pulse and level rise together and release wins over a repeat expiry.
    always_comb begin
        levelChange = (syncOut != level) && (debCnt == DebLast);
        levelRise   = levelChange && syncOut;
        levelFall   = levelChange && !syncOut;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debCnt <= '0;
            level  <= 1'b0;
        end else if (syncOut == level) begin
            debCnt <= '0;
        end else if (debCnt == DebLast) begin
            level  <= syncOut;
            debCnt <= '0;
        end else begin
            debCnt <= debCnt + 1'b1;
        end
    end

    always_comb begin
        stateNext  = state;
        repCntNext = repCnt;
        pulseNext  = 1'b0;
        heldNext   = held;
        if (levelFall) begin
            stateNext  = STATE_IDLE;
            repCntNext = '0;
            heldNext   = 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    heldNext = 1'b0;
                    if (levelRise) begin
                        pulseNext  = 1'b1;
                        stateNext  = STATE_DELAY;
                        repCntNext = RepDelayLoad;
                    end
                end
                STATE_DELAY: begin
                    if (repCnt == '0) begin
                        if (REPEAT_EN != 0) begin
                            pulseNext  = 1'b1;
                            heldNext   = 1'b1;
                            stateNext  = STATE_REPEAT;
                            repCntNext = RepRateLoad;
                        end else begin
                            stateNext  = STATE_HOLD;
                        end
                    end else begin
                        repCntNext = repCnt - 1'b1;
                    end
                end
                STATE_REPEAT: begin
                    if (repCnt == '0) begin
                        pulseNext  = 1'b1;
                        repCntNext = RepRateLoad;
                    end else begin
                        repCntNext = repCnt - 1'b1;
                    end
                end
                STATE_HOLD: begin
                    repCntNext = '0;
                end
                default: begin
                    stateNext  = STATE_IDLE;
                    repCntNext = '0;
                    heldNext   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= STATE_IDLE;
            repCnt <= '0;
            pulse  <= 1'b0;
            held   <= 1'b0;
        end else begin
            state  <= stateNext;
            repCnt <= repCntNext;
            pulse  <= pulseNext;
            held   <= heldNext;
        end
    end

endmodule
